mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one backing-memory port between the instruction-cache miss port (P0) and the data-cache
//  miss/write-back port (P1) of the 5-stage CPU. Grants one cache at a time and holds the grant for a
//  whole memory transaction. Registers the request into the memory-side latency controller and routes
//  the completion pulse back only to the granted cache. Sits between the two caches and the shared memory.
// PARAMETERS
//  ADDR_W          32  request address width
//  DATA_W          32  data width
//  TIMEOUT_CYCLES  64  max BUSY cycles before abort; 0 disables the watchdog
// PORTS
//  clk             in   1       clock; all state updates on rising edge
//  rst             in   1       asynchronous, active-high reset
//  p0_req_addr     in   ADDR_W  I-cache miss address
//  p0_req_valid    in   1       I-cache request; held until p0_res_valid
//  p0_res_data     out  DATA_W  read data to I-cache
//  p0_res_valid    out  1       one-cycle completion pulse to I-cache
//  p1_req_addr     in   ADDR_W  D-cache address
//  p1_req_data     in   DATA_W  D-cache write-back data
//  p1_req_wen      in   1       1 = write
//  p1_req_valid    in   1       D-cache request; held until p1_res_valid
//  p1_res_data     out  DATA_W  read data to D-cache
//  p1_res_valid    out  1       one-cycle completion pulse to D-cache
//  mem_req_addr    out  ADDR_W  registered address to memory
//  mem_req_data    out  DATA_W  registered write data
//  mem_req_wen     out  1       registered write enable (always 0 for P0)
//  mem_req_valid   out  1       high for the entire transaction
//  mem_res_data    in   DATA_W  memory read data
//  mem_res_valid   in   1       memory completion pulse
//  owner           out  2       one-hot current grant {P1,P0}; 00 when IDLE
//  err_timeout     out  1       sticky watchdog flag
// BEHAVIOUR
//  - Reset: state IDLE, owner=00, mem_req_* = 0, p*_res_valid = 0, err_timeout = 0, rr pointer -> P0 favoured.
//  - States: IDLE, BUSY. IDLE: any valid -> capture winner's addr/data/wen, owner, mem_req_valid=1, BUSY
//    next edge (1-cycle grant latency). BUSY: mem_req_* held constant until completion.
//  - Completion: mem_res_valid in BUSY -> p<owner>_res_valid=mem_res_valid combinationally same cycle;
//    other port's res_valid stays 0. p0/p1_res_data = mem_res_data on both ports at all times.
//  - On the completion edge: completing port is masked; if the other port is valid it is granted
//    directly (BUSY->BUSY, zero idle cycles), else IDLE with mem_req_valid=0. Completing port may
//    re-request from the next cycle.
//  - Requester dropping valid mid-transaction: ignored, transaction runs to completion.
//  - mem_res_valid while IDLE: ignored, no res_valid emitted.
//  - Watchdog: counter clears on grant, increments each BUSY cycle; reaching TIMEOUT_CYCLES without
//    mem_res_valid -> err_timeout=1 (sticky until rst), IDLE, mem_req_valid=0, no res_valid pulse.
//  - rst asserted mid-transaction: immediate return to reset values; in-flight request is dropped.
// CONFIGURATION
//  - ARB_ROUND_ROBIN_EN defined: simultaneous requests resolved round-robin; pointer flips to the
//    non-granted port on each grant.
//  - Not defined: fixed priority, P1 (data) always wins over P0; pointer logic absent.
// STRUCTURE
//  - mem_arbiter_defines.vh: state encodings (IDLE/BUSY), owner one-hot constants, port index constants.
//  - Sub-module rr_pick2: 2-request picker (req[1:0], pointer -> one-hot grant), combinational, with
//    the ARB_ROUND_ROBIN_EN / fixed-priority selection inside it.
// TESTING
//  1 P0 read 0x0000_0040 alone, memory answers after 3 cycles with 0xDEAD_BEEF -> mem_req_valid 1 cycle
//    after request, p0_res_valid one pulse with data 0xDEAD_BEEF, p1_res_valid stays 0.
//  2 P1 write 0x0000_0100 data 0x1234_5678 -> mem_req_wen=1, mem_req_data=0x1234_5678 stable throughout.
//  3 P0 and P1 valid same cycle, both held: RR build -> P0, then P1 back-to-back with no IDLE cycle;
//    fixed build -> P1 first, then P0.
//  4 P1 write-back followed immediately by P1 refill while P0 waits: RR grants P0 before second P1.
//  5 Memory never responds, TIMEOUT_CYCLES=8 -> err_timeout set after 8 BUSY cycles, owner=00,
//    mem_req_valid=0; err_timeout stays set until rst.
//  6 rst pulsed during BUSY -> all outputs return to reset values asynchronously, no res_valid emitted.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter:
// FSM state encoding, one-hot owner values and port indices.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_P0   = 2'b01;
  localparam logic [1:0] OWN_P1   = 2'b10;

  localparam int PORT_P0 = 0;
  localparam int PORT_P1 = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-requester picker: turns req[1:0] into a one-hot grant.
// With ARB_ROUND_ROBIN_EN defined, ties go to the port named by ptr;
// otherwise ties always go to P1 and there is no pointer input.
module rr_pick2 (
  input  logic [1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       ptr,
`endif
  output logic [1:0] grant
);
  import mem_port_arbiter_pkg::*;

  // Resolve a single winner; a lone requester always wins
  always_comb begin
    grant = OWN_NONE;
    if (req[PORT_P0] && req[PORT_P1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant = ptr ? OWN_P1 : OWN_P0;
`else
      grant = OWN_P1;
`endif
    end else if (req[PORT_P1]) begin
      grant = OWN_P1;
    end else if (req[PORT_P0]) begin
      grant = OWN_P0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between the I-cache (P0) and D-cache (P1).
// One transaction at a time; the grant is held until the memory completion
// pulse, which is routed back only to the owner. On completion the other port,
// if waiting, is granted on the same edge. A watchdog aborts a transaction
// after TIMEOUT_CYCLES busy cycles (0 disables it) and sets a sticky flag.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-breaking;
// without it P1 has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic              p0_req_valid,
  output logic [DATA_W-1:0] p0_res_data,
  output logic              p0_res_valid,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_data,
  input  logic              p1_req_wen,
  input  logic              p1_req_valid,
  output logic [DATA_W-1:0] p1_res_data,
  output logic              p1_res_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              mem_req_wen,
  output logic              mem_req_valid,
  input  logic [DATA_W-1:0] mem_res_data,
  input  logic              mem_res_valid,
  output logic [1:0]        owner,
  output logic              err_timeout
);
  import mem_port_arbiter_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t            state;
  logic [CNT_W-1:0]  wd_cnt;
  logic [1:0]        req;
  logic [1:0]        req_eff;
  logic [1:0]        grant;
  logic              done;
  logic              expire;
  logic              take;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              cap_wen;

  // While busy the owner is masked so a completion hands straight over to the other port
  assign req     = {p1_req_valid, p0_req_valid};
  assign req_eff = (state == ST_BUSY) ? (req & ~owner) : req;

  assign done   = (state == ST_BUSY) && mem_res_valid;
  assign expire = (state == ST_BUSY) && !mem_res_valid &&
                  (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);
  assign take   = (grant != OWN_NONE) && ((state == ST_IDLE) || done);

  // The I-cache never writes, so its data/wen are forced to zero
  assign cap_addr = grant[PORT_P1] ? p1_req_addr : p0_req_addr;
  assign cap_data = grant[PORT_P1] ? p1_req_data : '0;
  assign cap_wen  = grant[PORT_P1] & p1_req_wen;

  // Read data fans out to both caches; only the owner sees the valid pulse
  assign p0_res_data  = mem_res_data;
  assign p1_res_data  = mem_res_data;
  assign p0_res_valid = owner[PORT_P0] & mem_res_valid;
  assign p1_res_valid = owner[PORT_P1] & mem_res_valid;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // After each grant, favour the port that did not get it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (take) begin
      rr_ptr <= grant[PORT_P0];
    end
  end
`endif

  rr_pick2 u_pick (
    .req   (req_eff),
`ifdef ARB_ROUND_ROBIN_EN
    .ptr   (rr_ptr),
`endif
    .grant (grant)
  );

  // Grant / hold / release FSM with registered memory request and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      owner         <= OWN_NONE;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_valid <= 1'b0;
      wd_cnt        <= '0;
      err_timeout   <= 1'b0;
    end else begin
      if (take) begin
        state         <= ST_BUSY;
        owner         <= grant;
        mem_req_addr  <= cap_addr;
        mem_req_data  <= cap_data;
        mem_req_wen   <= cap_wen;
        mem_req_valid <= 1'b1;
        wd_cnt        <= '0;
      end else if (done || expire) begin
        state         <= ST_IDLE;
        owner         <= OWN_NONE;
        mem_req_wen   <= 1'b0;
        mem_req_valid <= 1'b0;
      end else if (state == ST_BUSY) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (expire) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] p0_req_addr;
  logic          p0_req_valid;
  logic [DW-1:0] p0_res_data;
  logic          p0_res_valid;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_data;
  logic          p1_req_wen;
  logic          p1_req_valid;
  logic [DW-1:0] p1_res_data;
  logic          p1_res_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic          mem_req_wen;
  logic          mem_req_valid;
  logic [DW-1:0] mem_res_data;
  logic          mem_res_valid;
  logic [1:0]    owner;
  logic          err_timeout;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .p0_req_addr(p0_req_addr), .p0_req_valid(p0_req_valid),
    .p0_res_data(p0_res_data), .p0_res_valid(p0_res_valid),
    .p1_req_addr(p1_req_addr), .p1_req_data(p1_req_data),
    .p1_req_wen(p1_req_wen), .p1_req_valid(p1_req_valid),
    .p1_res_data(p1_res_data), .p1_res_valid(p1_res_valid),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_wen(mem_req_wen), .mem_req_valid(mem_req_valid),
    .mem_res_data(mem_res_data), .mem_res_valid(mem_res_valid),
    .owner(owner), .err_timeout(err_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p0_req_addr = '0; p0_req_valid = 1'b0;
    p1_req_addr = '0; p1_req_data = '0; p1_req_wen = 1'b0; p1_req_valid = 1'b0;
    mem_res_data = 32'hDEAD_BEEF; mem_res_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- reference model (transaction level) ----------------
  int            m_owner;   // -1 none, 0 = P0, 1 = P1
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_wen;
  logic          m_err;
  int            m_age;     // completed busy cycles of current transaction
`ifdef ARB_ROUND_ROBIN_EN
  int            m_fav;
`endif

  task automatic model_reset();
    m_owner = -1; m_addr = '0; m_data = '0; m_wen = 1'b0; m_err = 1'b0; m_age = 0;
`ifdef ARB_ROUND_ROBIN_EN
    m_fav = 0;
`endif
  endtask

  function automatic int model_pick(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return m_fav;
`else
      return 1;
`endif
    end
    if (v1) return 1;
    if (v0) return 0;
    return -1;
  endfunction

  task automatic model_start(input int p);
    m_owner = p;
    m_age   = 0;
`ifdef ARB_ROUND_ROBIN_EN
    m_fav   = 1 - p;
`endif
    if (p == 1) begin
      m_addr = p1_req_addr; m_data = p1_req_data; m_wen = p1_req_wen;
    end else begin
      m_addr = p0_req_addr; m_wen = 1'b0;
    end
  endtask

  task automatic model_edge();
    int nxt;
    if (m_owner < 0) begin
      nxt = model_pick(p0_req_valid, p1_req_valid);
      if (nxt >= 0) model_start(nxt);
    end else if (mem_res_valid) begin
      if (m_owner == 0) nxt = p1_req_valid ? 1 : -1;
      else              nxt = p0_req_valid ? 0 : -1;
      if (nxt >= 0) model_start(nxt);
      else          m_owner = -1;
    end else begin
      m_age++;
      if (m_age >= TO) begin
        m_err   = 1'b1;
        m_owner = -1;
      end
    end
  endtask

  task automatic check_model(input int c);
    logic [1:0] e_own;
    e_own = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    chk($sformatf("rnd%0d owner", c), owner, e_own);
    chk($sformatf("rnd%0d req_valid", c), mem_req_valid, (m_owner >= 0));
    chk($sformatf("rnd%0d err", c), err_timeout, m_err);
    chk($sformatf("rnd%0d p0_res_valid", c), p0_res_valid, (m_owner == 0) && mem_res_valid);
    chk($sformatf("rnd%0d p1_res_valid", c), p1_res_valid, (m_owner == 1) && mem_res_valid);
    chk($sformatf("rnd%0d p0_res_data", c), p0_res_data, mem_res_data);
    chk($sformatf("rnd%0d p1_res_data", c), p1_res_data, mem_res_data);
    if (m_owner >= 0) begin
      chk($sformatf("rnd%0d addr", c), mem_req_addr, m_addr);
      chk($sformatf("rnd%0d wen", c), mem_req_wen, m_wen);
      if (m_owner == 1) chk($sformatf("rnd%0d wdata", c), mem_req_data, m_data);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v0, v1, wen, res;
    logic [1:0]  e_owner;
    logic        e_valid, e_wen, e_p0r, e_p1r;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [1:0] first, second;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    // Reset state
    clear_inputs();
    rst = 1'b1;
    #2;
    chk("reset owner", owner, 2'b00);
    chk("reset req_valid", mem_req_valid, 1'b0);
    chk("reset addr", mem_req_addr, 32'h0);
    chk("reset wen", mem_req_wen, 1'b0);
    chk("reset p0_res_valid", p0_res_valid, 1'b0);
    chk("reset p1_res_valid", p1_res_valid, 1'b0);
    chk("reset err", err_timeout, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single P0 read, single P1 write, stray completion while idle
    p0_req_addr = 32'h0000_0040;
    p1_req_addr = 32'h0000_0100;
    p1_req_data = 32'h1234_5678;
    mem_res_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      p0_req_valid  = tbl[i].v0;
      p1_req_valid  = tbl[i].v1;
      p1_req_wen    = tbl[i].wen;
      mem_res_valid = tbl[i].res;
      #1;
      chk($sformatf("vec%0d owner", i), owner, tbl[i].e_owner);
      chk($sformatf("vec%0d req_valid", i), mem_req_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d p0_res_valid", i), p0_res_valid, tbl[i].e_p0r);
      chk($sformatf("vec%0d p1_res_valid", i), p1_res_valid, tbl[i].e_p1r);
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d addr", i), mem_req_addr, tbl[i].e_addr);
        chk($sformatf("vec%0d wen", i), mem_req_wen, tbl[i].e_wen);
      end
      if (tbl[i].e_wen) chk($sformatf("vec%0d wdata", i), mem_req_data, 32'h1234_5678);
      if (tbl[i].e_p0r) chk($sformatf("vec%0d p0_res_data", i), p0_res_data, 32'hDEAD_BEEF);
      tick();
    end

    // Simultaneous requests, back-to-back hand-over with no idle cycle
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    first = 2'b01; second = 2'b10;
`else
    first = 2'b10; second = 2'b01;
`endif
    p0_req_addr = 32'h200; p1_req_addr = 32'h300;
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    tick();
    chk("t3 first owner", owner, first);
    chk("t3 first req_valid", mem_req_valid, 1'b1);
    tick();
    mem_res_valid = 1'b1;
    #1;
    chk("t3 first res", {p1_res_valid, p0_res_valid}, first);
    tick();
    mem_res_valid = 1'b0;
    if (first == 2'b01) p0_req_valid = 1'b0; else p1_req_valid = 1'b0;
    #1;
    chk("t3 second owner", owner, second);
    chk("t3 no idle gap", mem_req_valid, 1'b1);
    chk("t3 second addr", mem_req_addr, (second == 2'b01) ? 32'h200 : 32'h300);
    mem_res_valid = 1'b1;
    #1;
    chk("t3 second res", {p1_res_valid, p0_res_valid}, second);
    tick();
    mem_res_valid = 1'b0; p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    #1;
    chk("t3 back to idle", owner, 2'b00);

    // P1 write-back then P1 refill while P0 waits: P0 goes in between
    do_reset();
    p1_req_addr = 32'h400; p1_req_data = 32'hCAFE_0001; p1_req_wen = 1'b1; p1_req_valid = 1'b1;
    tick();
    chk("t4 wb owner", owner, 2'b10);
    chk("t4 wb wen", mem_req_wen, 1'b1);
    p0_req_addr = 32'h500; p0_req_valid = 1'b1;
    tick();
    chk("t4 wb data held", mem_req_data, 32'hCAFE_0001);
    mem_res_valid = 1'b1; p1_req_wen = 1'b0; p1_req_addr = 32'h440;
    #1;
    chk("t4 wb res", {p1_res_valid, p0_res_valid}, 2'b10);
    tick();
    mem_res_valid = 1'b0;
    #1;
    chk("t4 p0 owner", owner, 2'b01);
    chk("t4 p0 addr", mem_req_addr, 32'h500);
    chk("t4 p0 wen", mem_req_wen, 1'b0);
    mem_res_valid = 1'b1;
    tick();
    mem_res_valid = 1'b0; p0_req_valid = 1'b0;
    #1;
    chk("t4 refill owner", owner, 2'b10);
    chk("t4 refill addr", mem_req_addr, 32'h440);
    chk("t4 refill wen", mem_req_wen, 1'b0);
    mem_res_valid = 1'b1;
    tick();
    mem_res_valid = 1'b0; p1_req_valid = 1'b0;
    #1;
    chk("t4 idle", owner, 2'b00);

    // Watchdog: memory never answers
    do_reset();
    p0_req_addr = 32'h600; p0_req_valid = 1'b1;
    tick();
    chk("t5 granted", owner, 2'b01);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk($sformatf("t5 busy%0d req_valid", k), mem_req_valid, 1'b1);
      chk($sformatf("t5 busy%0d err", k), err_timeout, 1'b0);
    end
    p0_req_valid = 1'b0;
    tick();
    chk("t5 err set", err_timeout, 1'b1);
    chk("t5 owner", owner, 2'b00);
    chk("t5 req_valid", mem_req_valid, 1'b0);
    chk("t5 no res pulse", p0_res_valid, 1'b0);
    mem_res_valid = 1'b1;
    #1;
    chk("t5 idle res ignored", {p1_res_valid, p0_res_valid}, 2'b00);
    repeat (3) tick();
    mem_res_valid = 1'b0;
    chk("t5 err sticky", err_timeout, 1'b1);
    do_reset();
    chk("t5 err cleared", err_timeout, 1'b0);

    // Asynchronous reset in the middle of a transaction
    p1_req_addr = 32'h700; p1_req_data = 32'h55AA_55AA; p1_req_wen = 1'b1; p1_req_valid = 1'b1;
    tick();
    tick();
    chk("t6 busy", mem_req_valid, 1'b1);
    #2;
    rst = 1'b1; mem_res_valid = 1'b1;
    #1;
    chk("t6 owner", owner, 2'b00);
    chk("t6 req_valid", mem_req_valid, 1'b0);
    chk("t6 addr", mem_req_addr, 32'h0);
    chk("t6 data", mem_req_data, 32'h0);
    chk("t6 wen", mem_req_wen, 1'b0);
    chk("t6 no res", {p1_res_valid, p0_res_valid}, 2'b00);
    mem_res_valid = 1'b0; p1_req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      p0_req_valid  = ($urandom_range(0, 3) != 0);
      p1_req_valid  = ($urandom_range(0, 3) != 0);
      p0_req_addr   = $urandom;
      p1_req_addr   = $urandom;
      p1_req_data   = $urandom;
      p1_req_wen    = ($urandom_range(0, 1) == 1);
      mem_res_valid = ($urandom_range(0, 3) == 0);
      mem_res_data  = $urandom;
      rst           = ($urandom_range(0, 199) == 0);
      if (rst) model_reset();
      #1;
      check_model(c);
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
